// File: rtl/ltc2600_pkg.sv
// Shared definitions for the LTC2600 serial frame receiver and writer.
package ltc2600_pkg;

    localparam int unsigned FRAME_BITS = 24;
    localparam logic [3:0]  ADDR_ALL   = 4'hF;

    typedef enum logic [3:0] {
        CMD_WRITE_IN         = 4'b0000,
        CMD_UPDATE           = 4'b0001,
        CMD_WRITE_UPDATE_ALL = 4'b0010,
        CMD_WRITE_UPDATE     = 4'b0011,
        CMD_PWRDN            = 4'b0100,
        CMD_NOP              = 4'b1111
    } command_t;

    typedef enum logic [1:0] {
        ST_WAIT_HIGH = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_COMMIT    = 2'd3
    } rx_state_t;

    typedef struct packed {
        command_t   cmd;
        logic [3:0] addr;
    } frame_hdr_t;

endpackage

// File: rtl/ltc2600_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses
// derived from the synchronized level.
module ltc2600_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic pin,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= SYNC_STAGES'({chain, pin});
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level  = chain[SYNC_STAGES-1];
    assign rise_c = level & ~prev;
    assign fall_c = ~level & prev;

endmodule

// File: rtl/ltc2600_receive.sv
// LTC2600-style serial DAC receiver: captures csb-framed words from sck/sdi,
// decodes cmd/addr/data and models per-channel input, DAC and power-down state.
// Build option: define LTC2600_RECEIVE_SDO_EN to enable the sdo daisy-chain echo.
module ltc2600_receive
    import ltc2600_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned N_CH        = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sck,
    input  logic                    sdi,
    input  logic                    csb,
    output logic                    sdo,
    output logic                    frame_valid,
    output logic                    frame_error,
    output logic [3:0]              frame_cmd,
    output logic [3:0]              frame_addr,
    output logic [DATA_WIDTH-1:0]   frame_data,
    input  logic [$clog2(N_CH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_dac_code,
    output logic [DATA_WIDTH-1:0]   rd_input_code,
    output logic                    rd_pwrdn
);

    localparam int unsigned FB = DATA_WIDTH + 8;
    localparam int unsigned CW = $clog2(FB + 1);
    localparam int unsigned SW = $clog2(SYNC_STAGES + 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;
    logic csb_lvl, csb_rise, csb_fall;

    ltc2600_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rstn(rstn), .pin(sck),
        .level(sck_lvl), .rise_c(sck_rise), .fall_c(sck_fall)
    );
    ltc2600_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rstn(rstn), .pin(sdi),
        .level(sdi_lvl), .rise_c(sdi_rise), .fall_c(sdi_fall)
    );
    ltc2600_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
        .clk(clk), .rstn(rstn), .pin(csb),
        .level(csb_lvl), .rise_c(csb_rise), .fall_c(csb_fall)
    );

    logic unused_pins;
    assign unused_pins = ^{sck_lvl, sck_fall, sdi_rise, sdi_fall};

    rx_state_t             state_q, state_d;
    logic [SW-1:0]         settle_q;
    logic [FB-1:0]         shift_q;
    logic [CW-1:0]         count_q;
    logic                  settled, full, shift_en, frame_start, commit, addr_ok;
    command_t              f_cmd;
    logic [3:0]            f_addr;
    logic [DATA_WIDTH-1:0] f_data;
    logic [N_CH-1:0]       hit;

    logic [DATA_WIDTH-1:0] input_code [N_CH];
    logic [DATA_WIDTH-1:0] dac_code   [N_CH];
    logic [N_CH-1:0]       pwrdn;

    // The csb synchronizer resets to 1, so its level is trusted only once
    // the chain has refilled from the pin after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            settle_q <= '0;
        end else if (state_q == ST_WAIT_HIGH && !settled) begin
            settle_q <= settle_q + SW'(1);
        end
    end

    assign settled = (settle_q == SW'(SYNC_STAGES));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_WAIT_HIGH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_en    = 1'b0;
        frame_start = 1'b0;
        commit      = 1'b0;
        case (state_q)
            ST_WAIT_HIGH: if (settled && csb_lvl) state_d = ST_IDLE;
            ST_IDLE: begin
                if (csb_fall) begin
                    state_d     = ST_SHIFT;
                    frame_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (csb_rise) state_d = ST_COMMIT;
                else          shift_en = sck_rise;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                commit  = 1'b1;
            end
            default: state_d = ST_WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (frame_start) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (shift_en) begin
            shift_q <= {shift_q[FB-2:0], sdi_lvl};
            if (!full) count_q <= count_q + CW'(1);
        end
    end

    assign full    = (count_q == CW'(FB));
    assign f_cmd   = command_t'(shift_q[FB-1 -: 4]);
    assign f_addr  = shift_q[FB-5 -: 4];
    assign f_data  = shift_q[DATA_WIDTH-1:0];
    assign addr_ok = (f_addr == ADDR_ALL) || (32'(f_addr) < N_CH);

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            hit[i] = (f_addr == ADDR_ALL) || (32'(f_addr) == i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            frame_cmd   <= '0;
            frame_addr  <= '0;
            frame_data  <= '0;
        end else begin
            frame_valid <= commit && full;
            frame_error <= commit && !full;
            if (commit && full) begin
                frame_cmd  <= f_cmd;
                frame_addr <= f_addr;
                frame_data <= f_data;
            end
        end
    end

    // Channel register file; a write-update-all reads the pre-write input code
    // of unaddressed channels and the new data of addressed ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                input_code[i] <= '0;
                dac_code[i]   <= '0;
            end
            pwrdn <= '0;
        end else if (commit && full && addr_ok) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                case (f_cmd)
                    CMD_WRITE_IN: if (hit[i]) input_code[i] <= f_data;
                    CMD_UPDATE: begin
                        if (hit[i]) begin
                            dac_code[i] <= input_code[i];
                            pwrdn[i]    <= 1'b0;
                        end
                    end
                    CMD_WRITE_UPDATE_ALL: begin
                        if (hit[i]) input_code[i] <= f_data;
                        dac_code[i] <= hit[i] ? f_data : input_code[i];
                        pwrdn[i]    <= 1'b0;
                    end
                    CMD_WRITE_UPDATE: begin
                        if (hit[i]) begin
                            input_code[i] <= f_data;
                            dac_code[i]   <= f_data;
                            pwrdn[i]      <= 1'b0;
                        end
                    end
                    CMD_PWRDN: if (hit[i]) pwrdn[i] <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_dac_code   = '0;
        rd_input_code = '0;
        rd_pwrdn      = 1'b0;
        if (32'(rd_addr) < N_CH) begin
            rd_dac_code   = dac_code[rd_addr];
            rd_input_code = input_code[rd_addr];
            rd_pwrdn      = pwrdn[rd_addr];
        end
    end

`ifdef LTC2600_RECEIVE_SDO_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sdo <= 1'b0;
        end else if (state_q != ST_SHIFT) begin
            sdo <= 1'b0;
        end else if (sck_fall) begin
            sdo <= shift_q[FB-1];
        end
    end
`else
    assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_ltc2600_receive.sv
// Self-checking bench for ltc2600_receive: directed vector table, hand-built
// corner sequences and randomized frames against a channel-level model.
module tb_ltc2600_receive;

    localparam int unsigned DW   = 16;
    localparam int unsigned NCH  = 8;
    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sck = 1'b0;
    logic        sdi = 1'b0;
    logic        csb = 1'b1;
    logic [2:0]  rd_addr = '0;
    logic        sdo, frame_valid, frame_error, rd_pwrdn;
    logic [3:0]  frame_cmd, frame_addr;
    logic [15:0] frame_data, rd_dac_code, rd_input_code;

    int vectors = 0;
    int miscompares = 0;
    int nvalid = 0, nerr = 0, exp_valid = 0, exp_err = 0;

    logic [15:0] m_in  [NCH];
    logic [15:0] m_dac [NCH];
    logic        m_pd  [NCH];
    logic [3:0]  m_cmd, m_addr;
    logic [15:0] m_data;

    always #5 clk = ~clk;

    ltc2600_receive #(.DATA_WIDTH(DW), .N_CH(NCH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rstn(rstn), .sck(sck), .sdi(sdi), .csb(csb), .sdo(sdo),
        .frame_valid(frame_valid), .frame_error(frame_error),
        .frame_cmd(frame_cmd), .frame_addr(frame_addr), .frame_data(frame_data),
        .rd_addr(rd_addr), .rd_dac_code(rd_dac_code),
        .rd_input_code(rd_input_code), .rd_pwrdn(rd_pwrdn)
    );

    always @(negedge clk) begin
        if (frame_valid) nvalid++;
        if (frame_error) nerr++;
    end

    typedef struct {
        logic [3:0]  cmd;
        logic [3:0]  addr;
        logic [15:0] data;
        int          nbits;
        int          ch;
        logic [15:0] e_dac;
        logic [15:0] e_in;
        logic        e_pd;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_in[ch] = '0; m_dac[ch] = '0; m_pd[ch] = 1'b0;
        end
        m_cmd = '0; m_addr = '0; m_data = '0;
    endfunction

    // Frame semantics: the last 24 bits sent are cmd/addr/data.
    function automatic void model_frame(input logic [47:0] bits, input int nbits);
        logic [3:0]  c;
        logic [3:0]  a;
        logic [15:0] d;
        if (nbits < 24) begin
            exp_err++;
            return;
        end
        c = bits[23:20]; a = bits[19:16]; d = bits[15:0];
        exp_valid++;
        m_cmd = c; m_addr = a; m_data = d;
        if (a != 4'hF && 32'(a) >= NCH) return;
        for (int ch = 0; ch < NCH; ch++) begin
            if (!(a == 4'hF || 32'(a) == ch)) continue;
            case (c)
                4'h0: m_in[ch] = d;
                4'h1: begin m_dac[ch] = m_in[ch]; m_pd[ch] = 1'b0; end
                4'h2: m_in[ch] = d;
                4'h3: begin m_in[ch] = d; m_dac[ch] = d; m_pd[ch] = 1'b0; end
                4'h4: m_pd[ch] = 1'b1;
                default: ;
            endcase
        end
        if (c == 4'h2) begin
            for (int ch = 0; ch < NCH; ch++) begin
                m_dac[ch] = m_in[ch]; m_pd[ch] = 1'b0;
            end
        end
    endfunction

    task automatic check_all();
        for (int ch = 0; ch < NCH; ch++) begin
            rd_addr = 3'(ch);
            #1;
            chk($sformatf("dac[%0d]", ch), 32'(rd_dac_code), 32'(m_dac[ch]));
            chk($sformatf("input[%0d]", ch), 32'(rd_input_code), 32'(m_in[ch]));
            chk($sformatf("pwrdn[%0d]", ch), 32'(rd_pwrdn), 32'(m_pd[ch]));
        end
        chk("frame_cmd", 32'(frame_cmd), 32'(m_cmd));
        chk("frame_addr", 32'(frame_addr), 32'(m_addr));
        chk("frame_data", 32'(frame_data), 32'(m_data));
        chk("valid_pulses", 32'(nvalid), 32'(exp_valid));
        chk("error_pulses", 32'(nerr), 32'(exp_err));
    endtask

    // Drives one frame (MSB first of the low nbits of bits), checks the sdo
    // echo before each rising sck, and returns clocks from csb rise to a pulse.
    task automatic send_frame(input logic [47:0] bits, input int nbits, input int hp,
                              output int lat);
        logic exp_sdo;
        csb = 1'b0; sck = 1'b0;
        tick(hp);
        for (int k = 0; k < nbits; k++) begin
            sdi = bits[nbits-1-k];
            tick(hp);
            exp_sdo = 1'b0;
`ifdef LTC2600_RECEIVE_SDO_EN
            if (k >= 24) exp_sdo = bits[nbits-1-(k-24)];
`endif
            chk($sformatf("sdo before bit %0d", k), 32'(sdo), 32'(exp_sdo));
            sck = 1'b1;
            tick(hp);
            sck = 1'b0;
        end
        tick(hp);
        csb = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && (frame_valid || frame_error)) lat = c;
        end
    endtask

    task automatic run_frame(input logic [47:0] bits, input int nbits, input int hp);
        int lat;
        send_frame(bits, nbits, hp, lat);
        model_frame(bits, nbits);
        chk("latency", 32'(lat), 32'(SYNC + 2));
        check_all();
    endtask

    initial begin
        logic [47:0] bits;
        logic [3:0]  codes [6];
        logic [3:0]  c, a;
        int          sel, nb;

        model_reset();
        tick(5);
        chk("reset_sdo", 32'(sdo), 32'd0);
        chk("reset_valid", 32'(frame_valid), 32'd0);
        chk("reset_error", 32'(frame_error), 32'd0);
        check_all();
        rstn = 1'b1;
        tick(6);

        tbl[0] = '{4'h3, 4'h2, 16'hABCD, 24, 2, 16'hABCD, 16'hABCD, 1'b0};
        tbl[1] = '{4'h0, 4'hF, 16'h1234, 24, 2, 16'hABCD, 16'h1234, 1'b0};
        tbl[2] = '{4'h1, 4'h5, 16'h0000, 24, 5, 16'h1234, 16'h1234, 1'b0};
        tbl[3] = '{4'hF, 4'h0, 16'h0000, 24, 0, 16'h0000, 16'h1234, 1'b0};
        tbl[4] = '{4'h4, 4'h3, 16'h0000, 24, 3, 16'h0000, 16'h1234, 1'b1};
        tbl[5] = '{4'h1, 4'h3, 16'h0000, 24, 3, 16'h1234, 16'h1234, 1'b0};
        tbl[6] = '{4'h3, 4'h9, 16'hBEEF, 24, 1, 16'h0000, 16'h1234, 1'b0};
        tbl[7] = '{4'h2, 4'h6, 16'h5555, 24, 6, 16'h5555, 16'h5555, 1'b0};
        tbl[8] = '{4'h4, 4'hF, 16'h0000, 24, 7, 16'h1234, 16'h1234, 1'b1};
        tbl[9] = '{4'h3, 4'h2, 16'h0F0F, 20, 2, 16'h1234, 16'h1234, 1'b1};

        for (int i = 0; i < 10; i++) begin
            bits = {24'h0, tbl[i].cmd, tbl[i].addr, tbl[i].data};
            run_frame(bits, tbl[i].nbits, 4);
            rd_addr = 3'(tbl[i].ch);
            #1;
            chk($sformatf("tbl%0d dac", i), 32'(rd_dac_code), 32'(tbl[i].e_dac));
            chk($sformatf("tbl%0d input", i), 32'(rd_input_code), 32'(tbl[i].e_in));
            chk($sformatf("tbl%0d pwrdn", i), 32'(rd_pwrdn), 32'(tbl[i].e_pd));
        end

        // 32-bit frame: only the last 24 bits are decoded, leading byte echoes on sdo.
        bits = {16'h0, 8'hA5, 4'h3, 4'h1, 16'h00FF};
        run_frame(bits, 32, 4);
        rd_addr = 3'd1;
        #1;
        chk("long_frame dac1", 32'(rd_dac_code), 32'h00FF);

        // Reset in the middle of a frame, released while csb is still low.
        bits = {24'h0, 4'h3, 4'h4, 16'h7777};
        csb = 1'b0;
        tick(4);
        for (int k = 0; k < 24; k++) begin
            if (k == 10) begin
                rstn = 1'b0;
                tick(3);
                rstn = 1'b1;
                model_reset();
            end
            sdi = bits[23-k];
            tick(4);
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
        tick(4);
        csb = 1'b1;
        tick(20);
        check_all();
        bits = {24'h0, 4'h3, 4'h4, 16'h4321};
        run_frame(bits, 24, 4);

        codes[0] = 4'h0; codes[1] = 4'h1; codes[2] = 4'h2;
        codes[3] = 4'h3; codes[4] = 4'h4; codes[5] = 4'hF;
        for (int r = 0; r < 30; r++) begin
            sel = $urandom_range(0, 7);
            c   = (sel < 6) ? codes[sel] : 4'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            sel = $urandom_range(0, 9);
            nb  = (sel == 0) ? $urandom_range(4, 23) :
                  (sel == 1) ? $urandom_range(25, 40) : 24;
            bits = {24'($urandom), c, a, 16'($urandom)};
            run_frame(bits, nb, $urandom_range(3, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ltc2600_receive.md
LTC2600_RECEIVE -- requirements
Module: ltc2600_receive

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, data field width; frame length = DATA_WIDTH+8.
REQ-002 SHALL have parameter N_CH, default 8, number of modelled DAC channels (addresses 0..N_CH-1).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per pin input.
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 sck  input  1  serial clock from the DAC writer, asynchronous to clk.
REQ-007 sdi  input  1  serial data, MSB first, sampled on sck rising.
REQ-008 csb  input  1  active-low frame select.
REQ-009 sdo  output  1  echo of the shift register MSB (daisy-chain readback).
REQ-010 frame_valid  output  1  one-clk pulse per accepted frame.
REQ-011 frame_error  output  1  one-clk pulse per short (rejected) frame.
REQ-012 frame_cmd/frame_addr/frame_data  output  4/4/DATA_WIDTH  fields of the last accepted frame, held until the next one.
REQ-013 rd_addr  input  $clog2(N_CH)  channel readback select.
REQ-014 rd_dac_code/rd_input_code/rd_pwrdn  output  DATA_WIDTH/DATA_WIDTH/1  combinational readback of channel rd_addr.

Function
REQ-015 sck, sdi, csb SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on synchronized values.
REQ-016 Supported sck: high and low phases each >= 3 clk periods; faster sck is out of spec.
REQ-017 States: WAIT_HIGH, IDLE, SHIFT, COMMIT; reset enters WAIT_HIGH.
REQ-018 WAIT_HIGH -> IDLE when synchronized csb = 1; no capture before then (covers reset mid-frame).
REQ-019 IDLE -> SHIFT on synchronized csb falling; bit counter and shift register cleared.
REQ-020 In SHIFT each synchronized sck rising SHALL shift sdi into the LSB; counter saturates at DATA_WIDTH+8.
REQ-021 An sck rising detected in the same clk as the csb rising SHALL be ignored.
REQ-022 SHIFT -> COMMIT on csb rising; COMMIT -> IDLE unconditionally after one clk.
REQ-023 In COMMIT, count >= DATA_WIDTH+8: last DATA_WIDTH+8 bits decoded as cmd[4], addr[4], data, frame_valid = 1; count < DATA_WIDTH+8: frame_error = 1, no state change.
REQ-024 Latency: frame_valid/error and register updates SHALL occur SYNC_STAGES+2 clk after the csb pin rises.
REQ-025 Commands: 0000 input[n]<=data; 0001 dac[n]<=input[n], pwrdn[n]<=0; 0010 input[n]<=data then all dac<=input, all pwrdn<=0; 0011 input[n] and dac[n]<=data, pwrdn[n]<=0; 0100 pwrdn[n]<=1; 1111 and all others no-op (frame_valid still pulses).
REQ-026 addr 4'hF SHALL address all channels; addr in N_CH..14 SHALL change no register.
REQ-027 sdo SHALL update to shift-register MSB on each synchronized sck falling in SHIFT; 0 when not in SHIFT.

Reset
REQ-028 On rstn low: all input/dac codes 0, pwrdn 0, frame_* 0, frame_valid/error 0, sdo 0, counter 0, state WAIT_HIGH, synchronizers 1 for csb, 0 otherwise.

Configuration
REQ-029 Macro LTC2600_RECEIVE_SDO_EN defined: sdo echo per REQ-027; undefined: sdo tied 0 and echo logic absent; all else identical.

Structure
REQ-030 Package ltc2600_pkg SHALL hold command_t enum (codes per REQ-025), FRAME_BITS = 24, ADDR_ALL = 4'hF, shared with the writer.
REQ-031 Sub-module ltc2600_pin_sync (SYNC_STAGES synchronizer + rise/fall pulses) SHALL be instantiated per pin.

Verification
REQ-032 Frame 0011/0010/16'hABCD, sck = clk/8 -> frame_valid once; rd_addr=2 gives dac 16'hABCD, pwrdn 0.
REQ-033 0000/addr F/16'h1234 then 0001/addr 5 -> all input = 16'h1234, only dac[5] = 16'h1234, others 0.
REQ-034 csb high after 20 bits -> frame_error pulse, no register change, frame_* unchanged.
REQ-035 32 bits, last 24 = 0011/0001/16'h00FF -> dac[1] = 16'h00FF; with SDO_EN, sdo reproduces the first 8 bits delayed 24 sck.
REQ-036 rstn low mid-frame, released with csb low -> remaining bits ignored; next full frame after csb high accepted.
REQ-037 0100/addr 3 then 0001/addr 3 -> pwrdn[3] 1 then 0; addr 9 write -> no change, frame_valid pulses.
